// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word type and arbiter state encoding
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response bundle between the pipeline and mem_arbiter
//   arb modport : arbiter view (requests in, hits/loads out)
//   tb  modport : requester view (requests out, hits/loads in)
interface mem_arbiter_if
    import cpu_types_pkg::*;
(
    input logic CLK
);
    logic  iREN;
    word_t iaddr;
    logic  dREN;
    logic  dWEN;
    word_t daddr;
    word_t dstore;
    logic  ihit;
    word_t iload;
    logic  dhit;
    word_t dload;

    modport arb (
        input  CLK, iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ihit, iload, dhit, dload
    );

    modport tb (
        input  CLK, ihit, iload, dhit, dload,
        output iREN, iaddr, dREN, dWEN, daddr, dstore
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter, data priority, registered hit pulses
//   Inputs : CLK, RST (sync active-high), iREN/iaddr, dREN/dWEN/daddr/dstore, ramload
//   Outputs: ihit/iload, dhit/dload, ramREN/ramWEN/ramaddr/ramstore
//   LAT    : RAM access latency in cycles (1..15)
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned LAT = 2
) (
    input  logic  CLK,
    input  logic  RST,
    input  logic  iREN,
    input  word_t iaddr,
    input  logic  dREN,
    input  logic  dWEN,
    input  word_t daddr,
    input  word_t dstore,
    output logic  ihit,
    output word_t iload,
    output logic  dhit,
    output word_t dload,
    output logic  ramREN,
    output logic  ramWEN,
    output word_t ramaddr,
    output word_t ramstore,
    input  word_t ramload
);

    localparam logic [3:0] C_CNT_INIT = 4'(LAT - 1);

    arb_state_t r_state;
    logic [3:0] r_cnt;
    logic       r_op_is_d;
    logic       r_op_wr;
    word_t      r_addr_q;
    word_t      r_store_q;
    logic       r_ihit;
    logic       r_dhit;
    word_t      r_iload;
    word_t      r_dload;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_cnt     <= 4'd0;
            r_op_is_d <= 1'b0;
            r_op_wr   <= 1'b0;
            r_addr_q  <= '0;
            r_store_q <= '0;
            r_ihit    <= 1'b0;
            r_dhit    <= 1'b0;
            r_iload   <= '0;
            r_dload   <= '0;
        end else begin
            // Hits are single-cycle: cleared unless set by the final busy cycle.
            r_ihit <= 1'b0;
            r_dhit <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Data side wins when both stages are waiting.
                    if (dREN || dWEN) begin
                        r_op_is_d <= 1'b1;
                        r_op_wr   <= dWEN;
                        r_addr_q  <= daddr;
                        r_store_q <= dstore;
                        r_cnt     <= C_CNT_INIT;
                        r_state   <= BUSY;
                    end else if (iREN) begin
                        r_op_is_d <= 1'b0;
                        r_op_wr   <= 1'b0;
                        r_addr_q  <= iaddr;
                        r_cnt     <= C_CNT_INIT;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_op_wr) begin
                            if (r_op_is_d) begin
                                r_dload <= ramload;
                            end else begin
                                r_iload <= ramload;
                            end
                        end
                        r_ihit  <= !r_op_is_d;
                        r_dhit  <= r_op_is_d;
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                // One-cycle bubble so a still-held request is not re-accepted
                // before the pipeline has seen its hit.
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ihit     = r_ihit;
    assign dhit     = r_dhit;
    assign iload    = r_iload;
    assign dload    = r_dload;
    assign ramREN   = (r_state == BUSY) && !r_op_wr;
    assign ramWEN   = (r_state == BUSY) && r_op_wr;
    assign ramaddr  = r_addr_q;
    assign ramstore = r_store_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized checks of mem_arbiter at LAT=2 and LAT=1
module tb_mem_arbiter;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] ram_init(input logic [31:0] a);
        return (a == 32'h40) ? 32'h8C22_0004 : (a ^ 32'h5A5A_0000);
    endfunction

    // LAT=2 instance
    logic        iren2, dren2, dwen2;
    logic [31:0] iaddr2, daddr2, dstore2;
    logic        ihit2, dhit2, ramren2, ramwen2;
    logic [31:0] iload2, dload2, ramaddr2, ramstore2, ramload2;
    logic [31:0] mem2 [256];
    bit          wr2  [256];

    mem_arbiter #(.LAT(2)) u2 (
        .CLK(CLK), .RST(RST),
        .iREN(iren2), .iaddr(iaddr2),
        .dREN(dren2), .dWEN(dwen2), .daddr(daddr2), .dstore(dstore2),
        .ihit(ihit2), .iload(iload2), .dhit(dhit2), .dload(dload2),
        .ramREN(ramren2), .ramWEN(ramwen2), .ramaddr(ramaddr2),
        .ramstore(ramstore2), .ramload(ramload2)
    );

    always @(posedge CLK) begin
        if (ramwen2) begin
            mem2[ramaddr2[9:2]] <= ramstore2;
            wr2[ramaddr2[9:2]]  <= 1'b1;
        end
    end
    assign ramload2 = wr2[ramaddr2[9:2]] ? mem2[ramaddr2[9:2]] : ram_init(ramaddr2);

    // LAT=1 instance
    logic        iren1, dren1, dwen1;
    logic [31:0] iaddr1, daddr1, dstore1;
    logic        ihit1, dhit1, ramren1, ramwen1;
    logic [31:0] iload1, dload1, ramaddr1, ramstore1, ramload1;
    logic [31:0] mem1 [256];
    bit          wr1  [256];

    mem_arbiter #(.LAT(1)) u1 (
        .CLK(CLK), .RST(RST),
        .iREN(iren1), .iaddr(iaddr1),
        .dREN(dren1), .dWEN(dwen1), .daddr(daddr1), .dstore(dstore1),
        .ihit(ihit1), .iload(iload1), .dhit(dhit1), .dload(dload1),
        .ramREN(ramren1), .ramWEN(ramwen1), .ramaddr(ramaddr1),
        .ramstore(ramstore1), .ramload(ramload1)
    );

    always @(posedge CLK) begin
        if (ramwen1) begin
            mem1[ramaddr1[9:2]] <= ramstore1;
            wr1[ramaddr1[9:2]]  <= 1'b1;
        end
    end
    assign ramload1 = wr1[ramaddr1[9:2]] ? mem1[ramaddr1[9:2]] : ram_init(ramaddr1);

    // Independent reference contents for the randomized LAT=1 run
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return ref_wr[a[9:2]] ? ref_mem[a[9:2]] : ram_init(a);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int          kind;
        logic        want_i, want_d, d_wr, got_i, got_d;
        logic [31:0] ia, da, dv, exp_i, exp_dload;

        {iren2, dren2, dwen2, iaddr2, daddr2, dstore2} = '0;
        {iren1, dren1, dwen1, iaddr1, daddr1, dstore1} = '0;

        // Reset state
        RST = 1'b1;
        tick();
        tick();
        check("rst_ihit",    32'(ihit2), 32'd0);
        check("rst_dhit",    32'(dhit2), 32'd0);
        check("rst_iload",   iload2, 32'd0);
        check("rst_dload",   dload2, 32'd0);
        check("rst_ramren",  32'(ramren2), 32'd0);
        check("rst_ramwen",  32'(ramwen2), 32'd0);
        check("rst_ramaddr", ramaddr2, 32'd0);
        check("rst_ramst",   ramstore2, 32'd0);
        RST = 1'b0;
        tick();

        // Instruction read, LAT=2
        iren2 = 1'b1; iaddr2 = 32'h40;
        check("i_c0_ramren", 32'(ramren2), 32'd0);
        tick();
        check("i_c1_ramren", 32'(ramren2), 32'd1);
        check("i_c1_ramaddr", ramaddr2, 32'h40);
        check("i_c1_ihit", 32'(ihit2), 32'd0);
        tick();
        check("i_c2_ramren", 32'(ramren2), 32'd1);
        check("i_c2_ihit", 32'(ihit2), 32'd0);
        tick();
        check("i_c3_ihit", 32'(ihit2), 32'd1);
        check("i_c3_iload", iload2, 32'h8C22_0004);
        check("i_c3_ramren", 32'(ramren2), 32'd0);
        iren2 = 1'b0;
        tick();
        check("i_c4_ihit", 32'(ihit2), 32'd0);
        check("i_c4_ramren", 32'(ramren2), 32'd0);

        // Data write while idle
        dwen2 = 1'b1; daddr2 = 32'h100; dstore2 = 32'hDEAD_BEEF;
        tick();
        check("w_c1_ramwen", 32'(ramwen2), 32'd1);
        check("w_c1_ramren", 32'(ramren2), 32'd0);
        check("w_c1_ramaddr", ramaddr2, 32'h100);
        check("w_c1_ramst", ramstore2, 32'hDEAD_BEEF);
        tick();
        check("w_c2_ramwen", 32'(ramwen2), 32'd1);
        check("w_c2_dhit", 32'(dhit2), 32'd0);
        tick();
        check("w_c3_dhit", 32'(dhit2), 32'd1);
        check("w_c3_dload", dload2, 32'd0);
        check("w_c3_ramwen", 32'(ramwen2), 32'd0);
        dwen2 = 1'b0;
        tick();
        check("w_c4_dhit", 32'(dhit2), 32'd0);

        // Simultaneous instruction and data reads: data first
        iren2 = 1'b1; iaddr2 = 32'h44; dren2 = 1'b1; daddr2 = 32'h100;
        tick();
        check("s_c1_ramaddr", ramaddr2, 32'h100);
        check("s_c1_ramren", 32'(ramren2), 32'd1);
        tick();
        tick();
        check("s_c3_dhit", 32'(dhit2), 32'd1);
        check("s_c3_ihit", 32'(ihit2), 32'd0);
        check("s_c3_dload", dload2, 32'hDEAD_BEEF);
        dren2 = 1'b0;
        tick();
        check("s_c4_ramren", 32'(ramren2), 32'd0);
        check("s_c4_dhit", 32'(dhit2), 32'd0);
        tick();
        check("s_c5_ramaddr", ramaddr2, 32'h44);
        check("s_c5_ramren", 32'(ramren2), 32'd1);
        tick();
        check("s_c6_ihit", 32'(ihit2), 32'd0);
        tick();
        check("s_c7_ihit", 32'(ihit2), 32'd1);
        check("s_c7_dhit", 32'(dhit2), 32'd0);
        check("s_c7_iload", iload2, 32'h5A5A_0044);
        iren2 = 1'b0;
        tick();

        // Instruction request dropped mid-access
        iren2 = 1'b1; iaddr2 = 32'h80;
        tick();
        check("d_c1_ramren", 32'(ramren2), 32'd1);
        tick();
        iren2 = 1'b0;
        tick();
        check("d_c3_ihit", 32'(ihit2), 32'd1);
        check("d_c3_iload", iload2, 32'h5A5A_0080);
        tick();
        check("d_c4_ihit", 32'(ihit2), 32'd0);
        check("d_c4_ramren", 32'(ramren2), 32'd0);
        tick();
        check("d_c5_ramren", 32'(ramren2), 32'd0);

        // Reset in the middle of a data read
        dren2 = 1'b1; daddr2 = 32'h200;
        tick();
        check("r_c1_ramren", 32'(ramren2), 32'd1);
        tick();
        RST = 1'b1; dren2 = 1'b0;
        tick();
        RST = 1'b0;
        check("r_c3_ramren", 32'(ramren2), 32'd0);
        check("r_c3_dhit", 32'(dhit2), 32'd0);
        check("r_c3_dload", dload2, 32'd0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("r_nohit", 32'(dhit2), 32'd0);
            check("r_noren", 32'(ramren2), 32'd0);
        end

        // LAT=1 randomized instruction/data mix
        exp_dload = 32'd0;
        for (int n = 0; n < 100; n++) begin
            kind   = $urandom_range(0, 2);
            want_i = (kind != 1);
            want_d = (kind != 0);
            d_wr   = want_d && ($urandom_range(0, 1) == 1);
            ia     = 32'h300 + 32'(4 * $urandom_range(0, 15));
            da     = 32'h300 + 32'(4 * $urandom_range(0, 15));
            dv     = $urandom;
            if (want_d) begin
                if (d_wr) begin
                    ref_mem[da[9:2]] = dv;
                    ref_wr[da[9:2]]  = 1'b1;
                end else begin
                    exp_dload = ref_word(da);
                end
            end
            exp_i = ref_word(ia);

            iren1 = want_i; iaddr1 = ia;
            dren1 = want_d && !d_wr; dwen1 = want_d && d_wr;
            daddr1 = da; dstore1 = dv;
            got_i = 1'b0; got_d = 1'b0;
            for (int c = 1; c <= 8 && ((want_i && !got_i) || (want_d && !got_d)); c++) begin
                tick();
                check("x_concurrent", 32'(ihit1 & dhit1), 32'd0);
                if (dhit1) begin
                    got_d = 1'b1;
                    check("x_dhit_cycle", 32'(c), 32'd2);
                    check("x_dload", dload1, exp_dload);
                    dren1 = 1'b0; dwen1 = 1'b0;
                end
                if (ihit1) begin
                    got_i = 1'b1;
                    check("x_ihit_cycle", 32'(c), want_d ? 32'd5 : 32'd2);
                    check("x_iload", iload1, exp_i);
                    iren1 = 1'b0;
                end
            end
            check("x_got_i", 32'(got_i), 32'(want_i));
            check("x_got_d", 32'(got_d), 32'(want_d));
            iren1 = 1'b0; dren1 = 1'b0; dwen1 = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
